// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq -- reset sequencer for the board clock domain.
//
// Keeps every downstream reset domain asserted until the PLL reports lock,
// then releases the domains one at a time in index order (bit 0 first),
// STAGE_CYCLES cycles apart. A four-phase software reset request re-asserts
// all domains, acknowledges, and re-sequences once the request drops. Losing
// PLL lock at any point after the initial wait restarts the whole sequence.
//
// Optional build macro: RST_SEQ_LOCK_FILTER_EN
//   When defined, lock must be seen for LOCK_FILTER_CYCLES consecutive cycles
//   before the first release stage starts. Lock loss is always immediate.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   pll_locked_i  PLL lock indicator, already synchronous to clk_i
//   sw_rst_req_i  software reset request (four-phase handshake)
//   sw_rst_ack_o  software reset acknowledge
//   rst_o         per-domain active-high reset, bit 0 released first
//   ready_o       high when every domain is released
//   state_o       current FSM state encoding, for debug
// ---------------------------------------------------------------------------
module rst_seq #(
  parameter int N_DOMAINS          = 3,
  parameter int STAGE_CYCLES       = 16,
  parameter int LOCK_FILTER_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pll_locked_i,
  input  logic                 sw_rst_req_i,
  output logic                 sw_rst_ack_o,
  output logic [N_DOMAINS-1:0] rst_o,
  output logic                 ready_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_ASSERT = 3'd4,
    SW_ACK    = 3'd5
  } state_t;

  localparam int STAGE_W = $clog2(STAGE_CYCLES);
`ifdef RST_SEQ_LOCK_FILTER_EN
  // The filter count has to reach LOCK_FILTER_CYCLES-1 before the final
  // locked sample, so the shared counter grows if the filter needs more bits.
  localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int CNT_W  = (FILT_W > STAGE_W) ? FILT_W : STAGE_W;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
`else
  localparam int CNT_W = STAGE_W;
`endif
  localparam int IDX_W = $clog2(N_DOMAINS) + 1;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOMAINS - 1);

  // A filter length below one has no meaning; this block only exists when
  // the parameter is nonsensical and otherwise elaborates to nothing.
  if (LOCK_FILTER_CYCLES < 1) begin : g_lock_filter_invalid
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_DOMAINS-1:0]   rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;
  logic                   lock_lost;

  // Lock loss only matters once the sequencer has left the lock wait.
  assign lock_lost = !pll_locked_i &&
                     (state_q == RELEASE || state_q == RUN ||
                      state_q == SW_ASSERT || state_q == SW_ACK);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and next-output logic. Lock loss is applied last so that it
  // overrides whatever the per-state logic chose, including a software
  // reset request arriving on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    ack_d   = ack_q;

    case (state_q)
      HOLD: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
        ack_d   = 1'b0;
      end

      WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        ack_d   = 1'b0;
`ifdef RST_SEQ_LOCK_FILTER_EN
        // Counter holds the number of consecutive locked samples so far.
        if (!pll_locked_i) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        if (pll_locked_i) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
`endif
      end

      RELEASE: begin
        if (cnt_q == STAGE_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          for (int k = 0; k < N_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              rst_d[k] = 1'b0;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
        if (sw_rst_req_i) begin
          state_d = SW_ASSERT;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end

      SW_ASSERT: begin
        rst_d = '1;
        if (cnt_q == STAGE_LAST) begin
          state_d = SW_ACK;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SW_ACK: begin
        rst_d = '1;
        if (!sw_rst_req_i) begin
          state_d = RELEASE;
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase

    if (lock_lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end
  end

  assign sw_rst_ack_o = ack_q;
  assign rst_o        = rst_q;
  assign ready_o      = ready_q;
  assign state_o      = state_q;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer for the board's clock domain.
- Holds all downstream reset domains asserted until the PLL reports lock.
- Then releases the domains one at a time in index order, spaced by a fixed number of cycles.
- Also services a four-phase software reset request, and re-sequences automatically on PLL lock loss.
- Sits between the top-level reset pin/PLL and every block that consumes a local reset.

Parameters:
- N_DOMAINS, 3: number of reset domains; range 1..8.
- STAGE_CYCLES, 16: cycles between consecutive domain releases, and the software-reset hold length; range 2..65535.
- LOCK_FILTER_CYCLES, 64: consecutive locked cycles required before release. Used only with RST_SEQ_LOCK_FILTER_EN.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pll_locked_i  in  1  PLL lock indicator; already synchronous to clk_i.
- sw_rst_req_i  in  1  software reset request (four-phase handshake).
- sw_rst_ack_o  out  1  software reset acknowledge.
- rst_o  out  N_DOMAINS  per-domain active-high reset; bit 0 is released first.
- ready_o  out  1  high when every domain is released.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Clock and reset:
  - Single clock, clk_i; reset rst_i is synchronous and active-high.
  - While rst_i is high: state=HOLD, rst_o all ones, ready_o=0, sw_rst_ack_o=0, counter=0, domain index=0.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- Counter and index:
  - Counter width is $clog2(STAGE_CYCLES) bits, or wider if LOCK_FILTER_CYCLES needs it with the macro on.
  - Domain index width is $clog2(N_DOMAINS)+1.
  - The counter never wraps; it is cleared on every state change.
- State encodings: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, SW_ASSERT=4, SW_ACK=5.
- HOLD: first edge after rst_i deasserts -> WAIT_LOCK.
- WAIT_LOCK:
  - rst_o all ones.
  - pll_locked_i=1 sampled at edge E0 -> RELEASE, counter=0, index=0.
- RELEASE:
  - Counter increments each cycle.
  - When counter==STAGE_CYCLES-1: rst_o[index]<=0, counter<=0, index<=index+1.
  - Domain k is therefore released at edge E0+(k+1)*STAGE_CYCLES.
  - On the same edge that releases domain N_DOMAINS-1: state<=RUN, ready_o<=1.
  - Released bits stay 0; unreleased bits stay 1.
- RUN:
  - rst_o all zeros, ready_o=1.
  - sw_rst_req_i=1 -> SW_ASSERT; rst_o<=all ones and ready_o<=0 on that edge; counter=0.
- SW_ASSERT:
  - Hold all resets asserted for STAGE_CYCLES cycles.
  - When counter==STAGE_CYCLES-1 -> SW_ACK, sw_rst_ack_o<=1.
- SW_ACK:
  - rst_o all ones.
  - sw_rst_ack_o stays 1 until sw_rst_req_i=0 is sampled.
  - On that edge: sw_rst_ack_o<=0, state<=RELEASE, counter=0, index=0.
- Lock loss:
  - pll_locked_i=0 sampled in RELEASE, RUN, SW_ASSERT or SW_ACK -> WAIT_LOCK on that edge.
  - Same edge: rst_o<=all ones, ready_o<=0, sw_rst_ack_o<=0, counter=0, index=0.
  - Lock loss has priority over every other transition, including a simultaneous sw_rst_req_i.
- Pending requests: sw_rst_req_i is ignored outside RUN. A request still high when RUN is re-entered starts a new software reset immediately.
- rst_i mid-operation: in any state, returns to HOLD on the next edge with the reset values above.
- N_DOMAINS=1: RELEASE lasts exactly STAGE_CYCLES cycles, then RUN.

Optional Feature:
- Macro: RST_SEQ_LOCK_FILTER_EN.
- Defined: WAIT_LOCK counts consecutive cycles with pll_locked_i=1.
  - Any 0 clears the count.
  - RELEASE is entered on the edge where the count reaches LOCK_FILTER_CYCLES; that edge is E0.
- Not defined: a single sampled pll_locked_i=1 is enough; LOCK_FILTER_CYCLES is unused.
- Lock-loss detection is immediate in both builds.

Test Plan:
Default test parameters: N_DOMAINS=3, STAGE_CYCLES=4, macro off.
1. rst_i high 5 cycles, pll_locked_i=1 throughout -> rst_o=3'b111 until WAIT_LOCK exits at E0; rst_o=3'b110 at E0+4, 3'b100 at E0+8, 3'b000 with ready_o=1 at E0+12.
2. In RUN, raise sw_rst_req_i -> rst_o=3'b111 and ready_o=0 next edge; sw_rst_ack_o=1 four cycles later; drop req -> ack=0 next edge; domains re-release at +4/+8/+12.
3. Drop pll_locked_i for 1 cycle during RELEASE after domain 0 is released -> rst_o=3'b111 and state_o=1 next edge; full sequence restarts when lock returns.
4. Assert rst_i during SW_ACK -> state_o=0, sw_rst_ack_o=0, rst_o=3'b111 next edge.
5. Lock loss and sw_rst_req_i rising on the same edge in RUN -> WAIT_LOCK wins (state_o=1, ack never asserts).
6. Macro on, LOCK_FILTER_CYCLES=8: lock high 5, low 1, high 8 -> RELEASE entered only after the 8th consecutive locked cycle.
